// File: rtl/rule_pkt_sched.sv
// Packet-granular round-robin scheduler: one stream owns the registered output for a whole packet.
// Optional packet/beat statistics counters are built only when RULE_SCHED_STATS_EN is defined.
module rule_pkt_sched #(
    parameter int NUM_IN = 4,
    parameter int DWIDTH = 64,
    parameter int SRC_W  = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*DWIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_last,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    output logic [DWIDTH-1:0]        out_data,
    output logic                     out_last,
    output logic [SRC_W-1:0]         out_src,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              pkt_cnt,
    output logic [31:0]              beat_cnt,
    output logic                     dbg_state
);

    // Handshake: a beat moves on any rising edge where valid & ready are both high; valid never
    // waits on ready, and in_ready is derived only from registered state plus out_ready.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SRC_W-1:0]  grant_q, grant_d;
    logic [SRC_W-1:0]  rr_q, rr_d;
    logic [SRC_W-1:0]  winner;
    logic [SRC_W:0]    cand;
    logic              any_valid;
    logic              out_free;
    logic [DWIDTH-1:0] sel_data;
    logic              sel_last;
    logic              sel_valid;
    logic              accept;

    assign out_free  = !out_valid || out_ready;
    assign dbg_state = (state_q == BUSY);

    // First requester at or after rr_q, wrapping modulo NUM_IN.
    always_comb begin
        any_valid = 1'b0;
        winner    = '0;
        cand      = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = {1'b0, rr_q} + (SRC_W+1)'(k);
            if (cand >= (SRC_W+1)'(NUM_IN)) begin
                cand = cand - (SRC_W+1)'(NUM_IN);
            end
            if (!any_valid && in_valid[cand[SRC_W-1:0]]) begin
                any_valid = 1'b1;
                winner    = cand[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_last  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_q == SRC_W'(i)) begin
                sel_data  = in_data[i*DWIDTH +: DWIDTH];
                sel_last  = in_last[i];
                sel_valid = in_valid[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        in_ready = '0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = BUSY;
                    grant_d = winner;
                    rr_d    = (winner == SRC_W'(NUM_IN - 1)) ? '0 : winner + 1'b1;
                end
            end
            BUSY: begin
                for (int i = 0; i < NUM_IN; i++) begin
                    if (grant_q == SRC_W'(i)) begin
                        in_ready[i] = out_free;
                    end
                end
                accept = out_free && sel_valid;
                // Grant is held through gaps in the owner's valid; only its last beat releases it.
                if (accept && sel_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            if (accept) begin
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_src   <= grant_q;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef RULE_SCHED_STATS_EN
    logic out_fire;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_cnt  <= '0;
            beat_cnt <= '0;
        end else if (out_fire) begin
            beat_cnt <= beat_cnt + 32'd1;
            if (out_last) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end
`else
    assign pkt_cnt  = '0;
    assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_rule_pkt_sched.sv
// Directed bench for rule_pkt_sched: per-stream beat tables drive the inputs, an expected-beat
// queue checks every output transfer, and cycle-exact checks cover arbitration and stalls.
module tb_rule_pkt_sched;

    localparam int NI = 4;
    localparam int DW = 64;
    localparam int SW = 2;
    localparam int EW = SW + 1 + DW;

    logic              clk;
    logic              rst;
    logic [NI*DW-1:0]  in_data;
    logic [NI-1:0]     in_last;
    logic [NI-1:0]     in_valid;
    logic [NI-1:0]     in_ready;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [SW-1:0]     out_src;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       pkt_cnt;
    logic [31:0]       beat_cnt;
    logic              dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] exp_q[$];

    logic [DW:0]   src_tab[NI][32];
    int            src_hd[NI];
    int            src_tl[NI];
    logic [NI-1:0] gate;
    logic [NI-1:0] acc;

    rule_pkt_sched #(.NUM_IN(NI), .DWIDTH(DW), .SRC_W(SW)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_last (out_last),
        .out_src  (out_src),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .pkt_cnt  (pkt_cnt),
        .beat_cnt (beat_cnt),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [DW-1:0] beat_data(int s, int p, int b);
        return 64'hC0DE_0000_0000_0000 | (64'(s) << 32) | (64'(p) << 16) | 64'(b);
    endfunction

    function automatic logic [EW-1:0] exp_beat(int s, int p, int b, logic last);
        return {SW'(s), last, beat_data(s, p, b)};
    endfunction

    task automatic push_pkt(int s, int p, int n);
        for (int b = 0; b < n; b++) begin
            src_tab[s][src_tl[s]] = {(b == n - 1), beat_data(s, p, b)};
            src_tl[s]++;
        end
    endtask

    task automatic exp_pkt(int s, int p, int n);
        for (int b = 0; b < n; b++) begin
            exp_q.push_back(exp_beat(s, p, b, (b == n - 1)));
        end
    endtask

    // ---------------- driver ----------------
    // Samples handshakes before the edge, then presents each stream's next beat after it.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NI; i++) acc[i] = in_valid[i] & in_ready[i];
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            if (acc[i]) src_hd[i]++;
            if (src_hd[i] < src_tl[i] && !gate[i]) begin
                {in_last[i], in_data[i*DW +: DW]} = src_tab[i][src_hd[i]];
                in_valid[i] = 1'b1;
            end else begin
                in_valid[i] = 1'b0;
            end
        end
        #1;
    endtask

    task automatic reset_dut();
        rst       = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        out_ready = 1'b1;
        gate      = '0;
        for (int i = 0; i < NI; i++) begin
            src_hd[i] = 0;
            src_tl[i] = 0;
        end
        step();
        step();
        exp_q.delete();
        rst = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int c = 0;
        while ((exp_q.size() != 0 || out_valid) && c < budget) begin
            step();
            c++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL sb_extra: observed beat src %0d data %0h, expected none", out_src, out_data);
            end else begin
                chk("sb_beat", {out_src, out_last, out_data}, exp_q.pop_front());
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset_dut();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_src", out_src, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_state", dbg_state, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_beat_cnt", beat_cnt, 0);

        // Stream 2 alone: A,B,C.
        push_pkt(2, 1, 3);
        exp_pkt(2, 1, 3);
        step();
        chk("s1_ready_idle", in_ready, 4'b0000);
        step();
        chk("s1_ready_grant", in_ready, 4'b0100);
        chk("s1_busy", dbg_state, 1);
        chk("s1_no_out_yet", out_valid, 0);
        step();
        chk("s1_a_valid", out_valid, 1);
        chk("s1_a_data", out_data, beat_data(2, 1, 0));
        chk("s1_a_src", out_src, 2);
        chk("s1_a_last", out_last, 0);
        step();
        chk("s1_b_data", out_data, beat_data(2, 1, 1));
        chk("s1_b_last", out_last, 0);
        step();
        chk("s1_c_data", out_data, beat_data(2, 1, 2));
        chk("s1_c_last", out_last, 1);
        chk("s1_idle_after", dbg_state, 0);
        chk("s1_ready_after", in_ready, 4'b0000);
        step();
        chk("s1_drained", out_valid, 0);
        drain("s1_drain", 20);

        // All four streams with two 2-beat packets each.
        reset_dut();
        for (int p = 0; p < 2; p++) begin
            for (int s = 0; s < NI; s++) begin
                push_pkt(s, p, 2);
                exp_pkt(s, p, 2);
            end
        end
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            step();
            chk("s2_first_valid", out_valid, 1);
            chk("s2_first_src", out_src, k % NI);
            chk("s2_first_last", out_last, 0);
            step();
            chk("s2_second_src", out_src, k % NI);
            chk("s2_second_last", out_last, 1);
            step();
            chk("s2_bubble", out_valid, 0);
        end
        drain("s2_drain", 20);

        // Stream 1 pauses mid-packet while stream 0 waits.
        reset_dut();
        push_pkt(1, 0, 4);
        exp_pkt(1, 0, 4);
        exp_pkt(0, 0, 2);
        step();
        step();
        chk("s3_grant1", in_ready, 4'b0010);
        push_pkt(0, 0, 2);
        step();
        chk("s3_hold_c2", in_ready, 4'b0010);
        gate[1] = 1'b1;
        for (int g = 0; g < 5; g++) begin
            step();
            chk("s3_gap_ready", in_ready, 4'b0010);
            chk("s3_gap_busy", dbg_state, 1);
        end
        gate[1] = 1'b0;
        step();
        step();
        step();
        chk("s3_s1_done_src", out_src, 1);
        chk("s3_s1_done_last", out_last, 1);
        chk("s3_idle", dbg_state, 0);
        step();
        chk("s3_grant0", in_ready, 4'b0001);
        drain("s3_drain", 20);

        // Output stall pattern 1,0,0,1 during a 4-beat packet.
        reset_dut();
        push_pkt(0, 5, 4);
        exp_pkt(0, 5, 4);
        step();
        step();
        step();
        chk("s4_d0", out_data, beat_data(0, 5, 0));
        step();
        out_ready = 1'b0;
        #1;
        chk("s4_stall_ready", in_ready, 4'b0000);
        chk("s4_stall_d1a", out_data, beat_data(0, 5, 1));
        step();
        chk("s4_stall_d1b", out_data, beat_data(0, 5, 1));
        chk("s4_stall_valid", out_valid, 1);
        step();
        out_ready = 1'b1;
        #1;
        chk("s4_release_d1", out_data, beat_data(0, 5, 1));
        chk("s4_release_ready", in_ready, 4'b0001);
        step();
        chk("s4_d2", out_data, beat_data(0, 5, 2));
        step();
        chk("s4_d3", out_data, beat_data(0, 5, 3));
        chk("s4_d3_last", out_last, 1);
        drain("s4_drain", 20);

        // Empty packet on stream 3, then pointer wraps to 0.
        reset_dut();
        push_pkt(3, 7, 1);
        exp_pkt(3, 7, 1);
        exp_pkt(0, 8, 1);
        exp_pkt(3, 8, 1);
        step();
        step();
        chk("s5_grant3", in_ready, 4'b1000);
        step();
        chk("s5_empty_valid", out_valid, 1);
        chk("s5_empty_last", out_last, 1);
        chk("s5_empty_src", out_src, 3);
        chk("s5_empty_idle", dbg_state, 0);
        push_pkt(0, 8, 1);
        push_pkt(3, 8, 1);
        step();
        step();
        chk("s5_wrap_grant0", in_ready, 4'b0001);
        drain("s5_drain", 20);

        // Ten 3-beat packets, counters, then reset mid-packet.
        reset_dut();
        for (int p = 0; p < 10; p++) begin
            push_pkt(p % NI, p, 3);
            exp_pkt(p % NI, p, 3);
        end
        drain("s6_drain", 100);
`ifdef RULE_SCHED_STATS_EN
        chk("s6_pkt_cnt", pkt_cnt, 10);
        chk("s6_beat_cnt", beat_cnt, 30);
`else
        chk("s6_pkt_cnt_tied", pkt_cnt, 0);
        chk("s6_beat_cnt_tied", beat_cnt, 0);
`endif
        push_pkt(2, 9, 4);
        exp_pkt(2, 9, 4);
        step();
        step();
        step();
        step();
        chk("s6_mid_valid", out_valid, 1);
        chk("s6_mid_data", out_data, beat_data(2, 9, 1));
        rst = 1'b0;
        step();
        chk("s6_rst_valid", out_valid, 0);
        chk("s6_rst_state", dbg_state, 0);
        chk("s6_rst_ready", in_ready, 4'b0000);
        chk("s6_rst_pkt_cnt", pkt_cnt, 0);
        chk("s6_rst_beat_cnt", beat_cnt, 0);
        reset_dut();
        chk("s6_after_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rule_pkt_sched.md
# rule_pkt_sched

Packet-granular round-robin scheduler that shares one downstream rule-reduction path among NUM_IN upstream rule streams. Each stream carries rule beats for one packet terminated by a beat with `last` set; an empty packet is a lone `last` beat (sync marker). The scheduler grants one stream for a whole packet, forwards its beats through a registered output stage, then re-arbitrates. It sits between the per-engine rule FIFOs and the 2-to-1 reduction tree, so packet ordering per stream is never interleaved.

## Interface
Parameters:
- NUM_IN, 4: number of input streams, 2..16.
- DWIDTH, 64: rule beat width in bits, excluding `last`.
- SRC_W, $clog2(NUM_IN): width of `out_src`.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset; logic is in reset while rst==0 at a clock edge.
- in_data  in  NUM_IN*DWIDTH  stream i occupies bits [i*DWIDTH +: DWIDTH].
- in_last  in  NUM_IN  beat i is the final beat of its packet.
- in_valid  in  NUM_IN  beat i is present.
- in_ready  out  NUM_IN  beat i accepted when in_valid[i] & in_ready[i].
- out_data  out  DWIDTH  forwarded beat.
- out_last  out  1  forwarded beat ends its packet.
- out_src  out  SRC_W  index of the stream the beat came from.
- out_valid  out  1  output beat present.
- out_ready  in  1  downstream accepts when out_valid & out_ready.
- pkt_cnt  out  32  packets forwarded (only with RULE_SCHED_STATS_EN; see Configuration).
- beat_cnt  out  32  beats forwarded (only with RULE_SCHED_STATS_EN).

## Operation
- States: IDLE, BUSY. Registers: state, grant_q (SRC_W), rr_ptr (SRC_W), output register (data, last, src, valid).
- IDLE: in_ready all 0. If any in_valid, the winner is the first asserted index searching rr_ptr, rr_ptr+1, ... modulo NUM_IN. Next cycle: grant_q<=winner, state<=BUSY, rr_ptr<=(winner+1) mod NUM_IN. No in_valid: stay IDLE.
- BUSY: in_ready[grant_q] = !out_valid | out_ready; all other in_ready 0. An accepted beat loads the output register (data, last, src=grant_q, valid=1). An accepted beat with in_last=1 sets state<=IDLE.
- Output register: if out_valid & out_ready and no new beat loads, out_valid<=0. Load and drain in the same cycle is allowed (full throughput).
- Grant held while the granted stream deasserts in_valid mid-packet; other streams wait, no timeout.
- rr_ptr wraps from NUM_IN-1 to 0. A single requester is re-granted every packet.
- Empty packet (first beat has last=1): forwarded as one beat, grant released.
- in_valid on non-granted streams never affects BUSY; the winner is chosen only in IDLE.
- Reset: state=IDLE, rr_ptr=0, grant_q=0, out_valid=0, out_data=0, out_last=0, out_src=0, in_ready=0, counters=0. Reset mid-packet drops the output register contents and the partial packet; upstream must also be reset.

## Timing
- Arbitration: valid seen in IDLE at cycle t; in_ready high at t+1 (combinational from out_valid/out_ready and registered state).
- Data latency: beat accepted at cycle t appears on out_* at t+1.
- Last beat accepted at t, state IDLE at t+1, next grant effective t+2: exactly one bubble per packet at full rate.
- Steady-state throughput within a packet: one beat per cycle while out_ready=1.
- in_ready does not depend combinationally on in_valid.
- out_* stable while out_valid & !out_ready.

## Configuration
- RULE_SCHED_STATS_EN defined: pkt_cnt increments on each accepted output beat with out_last=1; beat_cnt increments on every accepted output beat. Both are 32-bit, wrap modulo 2^32, and reset to 0.
- Not defined: pkt_cnt and beat_cnt ports exist but are tied to 0; no counter logic.

## Test plan
- Reset, then NUM_IN=4 and stream 2 sends 3 beats (A,B,C; last on C) with out_ready=1 -> in_ready[2] high 1 cycle after valid, out shows A,B,C with src=2 on consecutive cycles, out_last only on C, then one IDLE cycle.
- Streams 0..3 all hold 2-beat packets continuously -> packet order by src 0,1,2,3,0,...; never interleaved; 3 cycles per packet.
- Stream 1 drops in_valid for 5 cycles mid-packet while stream 0 is valid -> in_ready[0] stays 0; stream 1 completes first, then stream 0 is granted.
- out_ready toggled 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated; out_data held while stalled.
- Only stream 3 sends an empty packet (single last beat), then rr wrap -> one output beat last=1 src=3; rr_ptr=0, so a simultaneous stream 0/3 request next grants 0.
- With RULE_SCHED_STATS_EN, 10 packets of 3 beats -> pkt_cnt=10, beat_cnt=30; reset (rst=0 one cycle) mid-packet -> counters 0, out_valid 0, state IDLE.
